// File: rtl/led_fade_pwm_pkg.sv
// led_fade_pwm_pkg: default build constants for the LED fade/PWM stage.
// These are the same values the chaser and board top use, so the whole LED
// path agrees on channel count, PWM resolution and fade timing.
package led_fade_pwm_pkg;

  localparam int LED_CHANNELS = 8;      // pattern / leds width
  localparam int LED_PWM_BITS = 8;      // duty resolution, period = 2**PWM_BITS clk
  localparam int LED_FADE_DIV = 65536;  // clk cycles per fade tick
  localparam int LED_DECAY    = 16;     // brightness removed per fade tick

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel of the comet-tail fader.
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   lit        in   synchronised chaser bit for this channel
//   peak       in   brightness to jump to while lit
//   fade_tick  in   1-cycle pulse, shared prescaler output
//   pwm_cnt    in   shared free-running PWM counter
//   led        out  registered PWM drive, 1 = LED on
// Holds brightness b (fades over time) and duty d (b sampled once per PWM
// period so a single period never mixes two duties).
module led_pwm_channel
  import led_fade_pwm_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS,
  parameter int DECAY    = LED_DECAY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lit,
  input  logic [PWM_BITS-1:0] peak,
  input  logic                fade_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] DEC = PWM_BITS'(DECAY);

  logic [PWM_BITS-1:0] b;
  logic [PWM_BITS-1:0] d;

  always_ff @(posedge clk) begin
    if (rst) begin
      b   <= '0;
      d   <= '0;
      led <= 1'b0;
    end else begin
      // lit beats a coincident fade tick; peak may also pull b down
      if (lit)            b <= peak;
      else if (fade_tick) b <= (b > DEC) ? b - DEC : '0;
      // duty only moves at the period boundary
      if (pwm_cnt == MAX) d <= b;
      // MAX is forced fully on, otherwise d on-cycles starting at cnt 0
      led <= (d == MAX) || (d > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: chaser pattern -> per-channel PWM LEDs with decaying tail.
//   clk      in   system clock, sole domain
//   rst      in   synchronous reset, active-high
//   pattern  in   chaser output, asynchronous to clk
//   peak     in   brightness for lit channels, quasi-static
//   leds     out  registered PWM drive, 1 = LED on
// Owns the pattern synchroniser, the PWM counter and the fade prescaler;
// all channels share these so every LED's PWM period is aligned.
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int CHANNELS = LED_CHANNELS,
  parameter int PWM_BITS = LED_PWM_BITS,
  parameter int FADE_DIV = LED_FADE_DIV,
  parameter int DECAY    = LED_DECAY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pattern,
  input  logic [PWM_BITS-1:0] peak,
  output logic [CHANNELS-1:0] leds
);

  localparam int PRE_W = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

  // two-flop synchroniser as a shift register; stage 1 is p_s
  logic [1:0][CHANNELS-1:0] sync_pipe;
  logic [CHANNELS-1:0]      p_s;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic [PRE_W-1:0]         pre_cnt;
  logic                     fade_tick;

  assign p_s       = sync_pipe[1];
  assign fade_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe <= '0;
      pwm_cnt   <= '0;
      pre_cnt   <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], pattern};
      pwm_cnt   <= pwm_cnt + 1'b1;  // natural wrap MAX -> 0
      pre_cnt   <= fade_tick ? '0 : pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS),
      .DECAY    (DECAY)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .lit       (p_s[i]),
      .peak      (peak),
      .fade_tick (fade_tick),
      .pwm_cnt   (pwm_cnt),
      .led       (leds[i])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm at PWM_BITS=4, FADE_DIV=8, DECAY=4, CHANNELS=8.
// Cycle numbering: edge 1 is the first clk edge after rst drops. Counters
// restart at reset, so pwm_cnt==15 precedes edges 16,32,... (duty loads) and
// fade ticks land on edges 8,16,24,... Expected leds per edge are queued.
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pattern = 8'h00;
  logic [3:0] peak = 4'd0;
  logic [7:0] leds;

  led_fade_pwm #(
    .CHANNELS (8),
    .PWM_BITS (4),
    .FADE_DIV (8),
    .DECAY    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pattern (pattern),
    .peak    (peak),
    .leds    (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      tag;
  } exp_t;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] pk;
    int         d_exp;
    string      tag;
  } vec_t;

  exp_t q[$];
  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic expect_const(input int start, input int len, input logic [7:0] v,
                              input string tag);
    for (int j = 0; j < len; j++) q.push_back('{start + j, v, tag});
  endtask

  // one 16-cycle PWM period with duty d on the channels in mask
  task automatic expect_period(input int start, input int d, input logic [7:0] mask,
                               input string tag);
    for (int j = 0; j < 16; j++)
      q.push_back('{start + j, ((d == 15) || (j < d)) ? mask : 8'h00, tag});
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc != cyc || leds !== e.val) begin
        bad++;
        $display("FAIL %s cyc=%0d (due %0d) got=%h exp=%h", e.tag, cyc, e.cyc, leds, e.val);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic [7:0] pat, input logic [3:0] pk);
    rst = 1'b1;
    pattern = pat;
    peak = pk;
    repeat (3) begin
      @(posedge clk);
      #1;
      total++;
      if (leds !== 8'h00) begin
        bad++;
        $display("FAIL reset got=%h exp=00", leds);
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect got=%0d exp=0", q.size());
      q.delete();
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    vecs[0] = '{8'h01, 4'd15, 15, "full_on"};
    vecs[1] = '{8'h01, 4'd5,  5,  "duty5"};
    vecs[2] = '{8'h81, 4'd9,  9,  "two_ch"};
    vecs[3] = '{8'hFF, 4'd1,  1,  "all_min"};
    vecs[4] = '{8'h00, 4'd12, 0,  "dark_after_lit"};
    vecs[5] = '{8'h01, 4'd0,  0,  "peak0"};
    vecs[6] = '{8'h80, 4'd14, 14, "ch7_d14"};

    // reset with everything lit: dark during reset and the whole first period
    do_reset(8'hFF, 4'd15);
    expect_const(1, 16, 8'h00, "reset_first_period");
    expect_period(17, 15, 8'hFF, "reset_then_full");
    run(32);

    // steady patterns: period 1 dark (d still 0), then duty = peak
    for (int i = 0; i < 7; i++) begin
      do_reset(vecs[i].pat, vecs[i].pk);
      expect_const(1, 16, 8'h00, {vecs[i].tag, "_p0"});
      expect_period(17, vecs[i].d_exp, vecs[i].pat, {vecs[i].tag, "_p1"});
      expect_period(33, vecs[i].d_exp, vecs[i].pat, {vecs[i].tag, "_p2"});
      run(48);
    end

    // decay A: pattern drops after edge 32; b 15->11(40)->7(48)->3(56)->0(64)
    do_reset(8'h01, 4'd15);
    expect_const(1, 16, 8'h00, "decA_p0");
    expect_period(17, 15, 8'h01, "decA_p1");
    expect_period(33, 15, 8'h01, "decA_p2");
    expect_period(49, 11, 8'h01, "decA_p3");
    expect_period(65, 3,  8'h01, "decA_p4");
    expect_period(81, 0,  8'h01, "decA_p5");
    expect_period(97, 0,  8'h01, "decA_nowrap");
    run(32);
    pattern = 8'h00;
    run(80);

    // decay B: drop after edge 40 so the 7 step lands on a duty load
    do_reset(8'h01, 4'd15);
    expect_const(1, 16, 8'h00, "decB_p0");
    expect_period(17, 15, 8'h01, "decB_p1");
    expect_period(33, 15, 8'h01, "decB_p2");
    expect_period(49, 15, 8'h01, "decB_p3");
    expect_period(65, 7,  8'h01, "decB_p4");
    expect_period(81, 0,  8'h01, "decB_p5");
    expect_period(97, 0,  8'h01, "decB_nowrap");
    run(40);
    pattern = 8'h00;
    run(72);

    // collision: 1-cycle lit pulse reaches p_s exactly on the edge-48 fade
    // tick; b must become 15 (not 7), then fade 11(56), 7(64), 3(72), 0(80)
    do_reset(8'h01, 4'd15);
    expect_const(1, 16, 8'h00, "coll_p0");
    expect_period(17, 15, 8'h01, "coll_p1");
    expect_period(33, 15, 8'h01, "coll_p2");
    expect_period(49, 11, 8'h01, "coll_p3");
    expect_period(65, 11, 8'h01, "coll_relit");
    expect_period(81, 3,  8'h01, "coll_p5");
    expect_period(97, 0,  8'h01, "coll_p6");
    run(32);
    pattern = 8'h00;
    run(13);
    pattern = 8'h01;
    run(1);
    pattern = 8'h00;
    run(66);

    // peak lowered 15->6 at pwm_cnt==7 of period 1: that period stays fully
    // on, duty 6 appears only after the next boundary
    do_reset(8'h01, 4'd15);
    expect_const(1, 16, 8'h00, "lower_p0");
    expect_period(17, 15, 8'h01, "glitch_free");
    expect_period(33, 6,  8'h01, "lower_p2");
    expect_period(49, 6,  8'h01, "lower_p3");
    run(23);
    peak = 4'd6;
    run(41);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL unconsumed_expect got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
